// File: rtl/rv32i_hazard_ctrl_pkg.sv
// rtl/rv32i_hazard_ctrl_pkg.sv - shared types and constants for the RV32I hazard controller
package rv32i_hazard_ctrl_pkg;

   // Width of the register index held in the scoreboard (RV32I has 32 GPRs).
   localparam int HZ_RD_W = 5;

   // EX operand source selects.
   localparam logic [1:0] FWD_SEL_RF    = 2'b00;
   localparam logic [1:0] FWD_SEL_EXMEM = 2'b01;
   localparam logic [1:0] FWD_SEL_MEMWB = 2'b10;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'b00,
      HZ_LD_STALL = 2'b01,
      HZ_MEM_WAIT = 2'b10
   } hz_state_t;

   // One in-flight instruction as seen by the hazard logic.
   typedef struct packed {
      logic               v;
      logic [HZ_RD_W-1:0] rd;
      logic               we;
      logic               ld;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '0;

   // A slot produces a register value only if it is valid, writes, and does not target x0.
   function automatic logic sb_is_writer(input sb_entry_t e);
      return e.v & e.we & (e.rd != '0);
   endfunction

endpackage

// File: rtl/rv32i_fwd_match.sv
// rtl/rv32i_fwd_match.sv - source-register versus scoreboard comparator
module rv32i_fwd_match
   import rv32i_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs_i,
   input  logic              use_i,
   input  sb_entry_t         ex_i,
   input  sb_entry_t         mem_i,
   output logic              load_hit_o,
   output logic [1:0]        sel_o
);

   logic [HZ_RD_W-1:0] rs_w;
   logic               ex_hit;
   logic               mem_hit;

   // Youngest producer wins; x0 never matches because writers never carry rd 0.
   always_comb begin
      rs_w       = HZ_RD_W'(rs_i);
      ex_hit     = use_i & sb_is_writer(ex_i)  & (ex_i.rd  == rs_w);
      mem_hit    = use_i & sb_is_writer(mem_i) & (mem_i.rd == rs_w);
      load_hit_o = ex_hit & ex_i.ld;
      if (ex_hit) begin
         sel_o = FWD_SEL_EXMEM;
      end else if (mem_hit) begin
         sel_o = FWD_SEL_MEMWB;
      end else begin
         sel_o = FWD_SEL_RF;
      end
   end

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// rtl/rv32i_hazard_ctrl.sv - RV32I stall/flush/bypass sequencer (perf counters under HAZARD_PERF_CNT_EN)
module rv32i_hazard_ctrl
   import rv32i_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int PERF_CNT_W = 32
) (
   input  logic              clk_i,
   input  logic              resetn_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_use_rs1_i,
   input  logic              id_use_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_we_i,
   input  logic              id_is_load_i,
   input  logic              ex_redirect_i,
   input  logic              dmem_req_i,
   input  logic              dmem_ready_i,
   output logic              stall_if_o,
   output logic              stall_id_o,
   output logic              freeze_o,
   output logic              flush_if_id_o,
   output logic              flush_id_ex_o,
   output logic [1:0]        fwd_rs1_sel_o,
   output logic [1:0]        fwd_rs2_sel_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_CNT_W-1:0] stall_cnt_o,
   output logic [PERF_CNT_W-1:0] flush_cnt_o,
   output logic [PERF_CNT_W-1:0] wait_cnt_o
`endif
);

   sb_entry_t  ex_q, ex_d;
   sb_entry_t  mem_q, mem_d;
   sb_entry_t  id_entry;
   logic [1:0] fwd1_q, fwd1_d;
   logic [1:0] fwd2_q, fwd2_d;
   hz_state_t  state_q, state_d;

   logic [1:0] sel1, sel2;
   logic       ld_hit1, ld_hit2;
   logic       frozen;
   logic       redirect;
   logic       load_use;
   logic       bubble;

   rv32i_fwd_match #(.REG_AW(REG_AW)) u_match_rs1 (
      .rs_i       (id_rs1_i),
      .use_i      (id_use_rs1_i),
      .ex_i       (ex_q),
      .mem_i      (mem_q),
      .load_hit_o (ld_hit1),
      .sel_o      (sel1)
   );

   rv32i_fwd_match #(.REG_AW(REG_AW)) u_match_rs2 (
      .rs_i       (id_rs2_i),
      .use_i      (id_use_rs2_i),
      .ex_i       (ex_q),
      .mem_i      (mem_q),
      .load_hit_o (ld_hit2),
      .sel_o      (sel2)
   );

   // Hazard classification in priority order: memory wait, redirect, load-use.
   always_comb begin
      frozen   = dmem_req_i & ~dmem_ready_i;
      redirect = ~frozen & ex_redirect_i;
      load_use = ~frozen & ~redirect & id_valid_i & (ld_hit1 | ld_hit2);
      bubble   = redirect | load_use;
   end

   // Pipeline control outputs; held low while reset is asserted so they drop asynchronously.
   always_comb begin
      stall_if_o    = resetn_i & (frozen | load_use);
      stall_id_o    = resetn_i & (frozen | load_use);
      freeze_o      = resetn_i & frozen;
      flush_if_id_o = resetn_i & redirect;
      flush_id_ex_o = resetn_i & bubble;
      fwd_rs1_sel_o = fwd1_q;
      fwd_rs2_sel_o = fwd2_q;
   end

   // Scoreboard and bypass-select advance; everything holds while the data memory is busy.
   always_comb begin
      ex_d     = ex_q;
      mem_d    = mem_q;
      fwd1_d   = fwd1_q;
      fwd2_d   = fwd2_q;
      id_entry = '{v: id_valid_i, rd: HZ_RD_W'(id_rd_i), we: id_we_i, ld: id_is_load_i};
      if (!frozen) begin
         mem_d = ex_q;
         if (bubble || !id_valid_i) begin
            ex_d   = SB_EMPTY;
            fwd1_d = FWD_SEL_RF;
            fwd2_d = FWD_SEL_RF;
         end else begin
            ex_d   = id_entry;
            fwd1_d = sel1;
            fwd2_d = sel2;
         end
      end
   end

   // Sequencer state: tracks whether the pipe is running, bubbling a load, or waiting on memory.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HZ_RUN: begin
            if (frozen) begin
               state_d = HZ_MEM_WAIT;
            end else if (load_use) begin
               state_d = HZ_LD_STALL;
            end
         end
         HZ_LD_STALL: begin
            state_d = frozen ? HZ_MEM_WAIT : HZ_RUN;
         end
         HZ_MEM_WAIT: begin
            if (dmem_ready_i) begin
               state_d = HZ_RUN;
            end
         end
         default: state_d = HZ_RUN;
      endcase
   end

   // State registers.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         ex_q    <= SB_EMPTY;
         mem_q   <= SB_EMPTY;
         fwd1_q  <= FWD_SEL_RF;
         fwd2_q  <= FWD_SEL_RF;
         state_q <= HZ_RUN;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         fwd1_q  <= fwd1_d;
         fwd2_q  <= fwd2_d;
         state_q <= state_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [PERF_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   // Event counters; they wrap through zero on overflow.
   always_comb begin
      stall_cnt_d = stall_cnt_q + PERF_CNT_W'(load_use);
      flush_cnt_d = flush_cnt_q + PERF_CNT_W'(redirect);
      wait_cnt_d  = wait_cnt_q  + PERF_CNT_W'(frozen);
      stall_cnt_o = stall_cnt_q;
      flush_cnt_o = flush_cnt_q;
      wait_cnt_o  = wait_cnt_q;
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end
`else
   if (PERF_CNT_W < 1) begin : g_no_perf_cnt
   end
`endif

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// tb/tb_rv32i_hazard_ctrl.sv - self-checking bench for rv32i_hazard_ctrl
module tb_rv32i_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn;
   logic       id_valid, id_use_rs1, id_use_rs2, id_we, id_is_load;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       ex_redirect, dmem_req, dmem_ready;
   logic       stall_if, stall_id, freeze, flush_if_id, flush_id_ex;
   logic [1:0] fwd1, fwd2;
   logic [4:0] ctl;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

   assign ctl = {stall_if, stall_id, freeze, flush_if_id, flush_id_ex};

   rv32i_hazard_ctrl dut (
      .clk_i         (clk),
      .resetn_i      (resetn),
      .id_valid_i    (id_valid),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_use_rs1_i  (id_use_rs1),
      .id_use_rs2_i  (id_use_rs2),
      .id_rd_i       (id_rd),
      .id_we_i       (id_we),
      .id_is_load_i  (id_is_load),
      .ex_redirect_i (ex_redirect),
      .dmem_req_i    (dmem_req),
      .dmem_ready_i  (dmem_ready),
      .stall_if_o    (stall_if),
      .stall_id_o    (stall_id),
      .freeze_o      (freeze),
      .flush_if_id_o (flush_if_id),
      .flush_id_ex_o (flush_id_ex),
      .fwd_rs1_sel_o (fwd1),
      .fwd_rs2_sel_o (fwd2)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt_o   (stall_cnt),
      .flush_cnt_o   (flush_cnt),
      .wait_cnt_o    (wait_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: the two instructions downstream of ID, youngest first.
   typedef struct { bit v; int rd; bit we; bit ld; } instr_t;
   instr_t   pipe [2];
   int       exp_fwd1, exp_fwd2;
   bit [4:0] exp_ctl;
   bit       m_frz, m_redir, m_lu;
   int       n_stall, n_flush, n_wait;

   function automatic bit produces(instr_t p, int r);
      return p.v && p.we && p.rd != 0 && p.rd == r;
   endfunction

   function automatic int src_for(int r, bit used);
      if (!used) return 0;
      if (produces(pipe[0], r)) return 1;
      if (produces(pipe[1], r)) return 2;
      return 0;
   endfunction

   task automatic model_reset();
      pipe[0]  = '{v: 0, rd: 0, we: 0, ld: 0};
      pipe[1]  = '{v: 0, rd: 0, we: 0, ld: 0};
      exp_fwd1 = 0;
      exp_fwd2 = 0;
      n_stall  = 0;
      n_flush  = 0;
      n_wait   = 0;
   endtask

   task automatic model_eval();
      m_frz   = dmem_req && !dmem_ready;
      m_redir = !m_frz && ex_redirect;
      m_lu    = !m_frz && !m_redir && id_valid && pipe[0].ld &&
                ((id_use_rs1 && produces(pipe[0], id_rs1)) ||
                 (id_use_rs2 && produces(pipe[0], id_rs2)));
      exp_ctl = {m_frz || m_lu, m_frz || m_lu, m_frz, m_redir, m_redir || m_lu};
   endtask

   task automatic model_commit();
      instr_t nxt;
      if (m_lu)    n_stall++;
      if (m_redir) n_flush++;
      if (m_frz) begin
         n_wait++;
         return;
      end
      if (m_redir || m_lu || !id_valid) begin
         exp_fwd1 = 0;
         exp_fwd2 = 0;
         nxt = '{v: 0, rd: 0, we: 0, ld: 0};
      end else begin
         exp_fwd1 = src_for(id_rs1, id_use_rs1);
         exp_fwd2 = src_for(id_rs2, id_use_rs2);
         nxt = '{v: 1, rd: int'(id_rd), we: id_we, ld: id_is_load};
      end
      pipe[1] = pipe[0];
      pipe[0] = nxt;
   endtask

   task automatic drv(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                      input int rd, input bit we, input bit ld,
                      input bit redir, input bit req, input bit rdy);
      id_valid    = v;
      id_rs1      = 5'(rs1);
      id_rs2      = 5'(rs2);
      id_use_rs1  = u1;
      id_use_rs2  = u2;
      id_rd       = 5'(rd);
      id_we       = we;
      id_is_load  = ld;
      ex_redirect = redir;
      dmem_req    = req;
      dmem_ready  = rdy;
   endtask

   task automatic drv_idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic to_negedge();
      model_eval();
      @(negedge clk);
   endtask

   task automatic to_next();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 2; i++) begin
         drv_idle();
         to_negedge();
         to_next();
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      drv(1, 1, 2, 1, 1, 3, 1, 1, 1, 1, 0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if (ctl !== 5'b00000) begin
         errors++;
         $display("FAIL reset_ctl got %b exp %b", ctl, 5'b00000);
      end
      checks++;
      if ({fwd1, fwd2} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_fwd got %b exp %b", {fwd1, fwd2}, 4'b0000);
      end
      drv_idle();
      resetn = 1'b1;
   endtask

   task automatic test_fwd_exmem();
      drv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0);
      to_negedge();
      to_next();
      drv(1, 5, 3, 1, 1, 6, 1, 0, 0, 0, 0);
      to_negedge();
      checks++;
      if (ctl !== 5'b00000) begin
         errors++;
         $display("FAIL exmem_nostall got %b exp %b", ctl, 5'b00000);
      end
      to_next();
      checks++;
      if ({fwd1, fwd2} !== 4'b0100) begin
         errors++;
         $display("FAIL exmem_fwd got %b exp %b", {fwd1, fwd2}, 4'b0100);
      end
      drain();
   endtask

   task automatic test_fwd_memwb();
      drv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0);
      to_negedge(); to_next();
      drv_idle();
      to_negedge(); to_next();
      drv(1, 5, 4, 1, 1, 7, 1, 0, 0, 0, 0);
      to_negedge(); to_next();
      checks++;
      if ({fwd1, fwd2} !== 4'b1000) begin
         errors++;
         $display("FAIL memwb_fwd got %b exp %b", {fwd1, fwd2}, 4'b1000);
      end
      drv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0);
      to_negedge(); to_next();
      drv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0);
      to_negedge(); to_next();
      drv(1, 5, 5, 1, 1, 10, 1, 0, 0, 0, 0);
      to_negedge(); to_next();
      checks++;
      if ({fwd1, fwd2} !== 4'b0101) begin
         errors++;
         $display("FAIL newest_wins got %b exp %b", {fwd1, fwd2}, 4'b0101);
      end
      drain();
   endtask

   task automatic test_load_use();
      drv(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0);
      to_negedge(); to_next();
      drv(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0);
      to_negedge();
      checks++;
      if (ctl !== 5'b11001) begin
         errors++;
         $display("FAIL lu_stall got %b exp %b", ctl, 5'b11001);
      end
      to_next();
      checks++;
      if ({fwd1, fwd2} !== 4'b0000) begin
         errors++;
         $display("FAIL lu_bubble_fwd got %b exp %b", {fwd1, fwd2}, 4'b0000);
      end
      to_negedge();
      checks++;
      if (ctl !== 5'b00000) begin
         errors++;
         $display("FAIL lu_single got %b exp %b", ctl, 5'b00000);
      end
      to_next();
      checks++;
      if ({fwd1, fwd2} !== 4'b1010) begin
         errors++;
         $display("FAIL lu_fwd got %b exp %b", {fwd1, fwd2}, 4'b1010);
      end
      drain();
   endtask

   task automatic test_redirect();
      drv(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0);
      to_negedge(); to_next();
      drv(1, 8, 0, 1, 0, 9, 1, 0, 1, 0, 0);
      to_negedge();
      checks++;
      if (ctl !== 5'b00011) begin
         errors++;
         $display("FAIL redirect_ctl got %b exp %b", ctl, 5'b00011);
      end
      to_next();
      drv_idle();
      to_negedge();
      checks++;
      if (ctl !== 5'b00000) begin
         errors++;
         $display("FAIL redirect_once got %b exp %b", ctl, 5'b00000);
      end
      to_next();
      drain();
   endtask

   task automatic test_freeze();
      drv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0);
      to_negedge(); to_next();
      drv(1, 5, 3, 1, 1, 6, 1, 0, 0, 0, 0);
      to_negedge(); to_next();
      for (int i = 0; i < 3; i++) begin
         drv(1, 1, 6, 1, 1, 0, 0, 0, i > 0, 1, 0);
         to_negedge();
         checks++;
         if (ctl !== 5'b11100) begin
            errors++;
            $display("FAIL freeze_ctl[%0d] got %b exp %b", i, ctl, 5'b11100);
         end
         to_next();
         checks++;
         if ({fwd1, fwd2} !== 4'b0100) begin
            errors++;
            $display("FAIL freeze_hold[%0d] got %b exp %b", i, {fwd1, fwd2}, 4'b0100);
         end
      end
      drv(1, 1, 6, 1, 1, 0, 0, 0, 1, 1, 1);
      to_negedge();
      checks++;
      if (ctl !== 5'b00011) begin
         errors++;
         $display("FAIL freeze_release got %b exp %b", ctl, 5'b00011);
      end
      to_next();
      drain();
   endtask

   task automatic test_x0();
      drv(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0);
      to_negedge(); to_next();
      drv(1, 0, 0, 1, 1, 3, 1, 0, 0, 0, 0);
      to_negedge(); to_next();
      checks++;
      if ({fwd1, fwd2} !== 4'b0000) begin
         errors++;
         $display("FAIL x0_fwd got %b exp %b", {fwd1, fwd2}, 4'b0000);
      end
      drv(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
      to_negedge(); to_next();
      drv(1, 0, 0, 1, 1, 4, 1, 0, 0, 0, 0);
      to_negedge();
      checks++;
      if (ctl !== 5'b00000) begin
         errors++;
         $display("FAIL x0_nostall got %b exp %b", ctl, 5'b00000);
      end
      to_next();
      drain();
   endtask

   task automatic test_async_reset();
      drv(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0);
      to_negedge(); to_next();
      drv(1, 5, 0, 1, 0, 8, 1, 1, 0, 0, 0);
      to_negedge(); to_next();
      drv(1, 8, 0, 1, 0, 9, 1, 0, 0, 0, 0);
      to_negedge();
      checks++;
      if ({ctl, fwd1} !== 7'b1100101) begin
         errors++;
         $display("FAIL arst_pre got %b exp %b", {ctl, fwd1}, 7'b1100101);
      end
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if ({ctl, fwd1, fwd2} !== 9'b0) begin
         errors++;
         $display("FAIL arst_outputs got %b exp %b", {ctl, fwd1, fwd2}, 9'b0);
      end
      model_reset();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      to_negedge();
      checks++;
      if (ctl !== 5'b00000) begin
         errors++;
         $display("FAIL arst_run got %b exp %b", ctl, 5'b00000);
      end
      to_next();
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drv($urandom_range(3, 0) != 0, $urandom_range(3, 0), $urandom_range(3, 0),
             $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
             $urandom_range(3, 0), $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0,
             $urandom_range(7, 0) == 0, $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1);
         to_negedge();
         checks++;
         if (ctl !== exp_ctl) begin
            errors++;
            $display("FAIL rand_ctl[%0d] got %b exp %b", i, ctl, exp_ctl);
         end
         to_next();
         checks++;
         if ({fwd1, fwd2} !== {2'(exp_fwd1), 2'(exp_fwd2)}) begin
            errors++;
            $display("FAIL rand_fwd[%0d] got %b exp %b", i, {fwd1, fwd2},
                     {2'(exp_fwd1), 2'(exp_fwd2)});
         end
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if ({stall_cnt, flush_cnt, wait_cnt} !== {32'(n_stall), 32'(n_flush), 32'(n_wait)}) begin
         errors++;
         $display("FAIL perf_cnt got %0d/%0d/%0d exp %0d/%0d/%0d",
                  stall_cnt, flush_cnt, wait_cnt, n_stall, n_flush, n_wait);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_fwd_exmem();
      test_fwd_memwb();
      test_load_use();
      test_redirect();
      test_freeze();
      test_x0();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
